cu_vertex_cache_fill_engine: RTL and testbench

- Producer side of the vertex cache fill interface. It consumes the miss commands the vertex cache forwards to memory and tracks them by command tag.
- It watches the returning read data and read responses, extracts the requested vertex word, and drives an EdgeDataCache fill record back into the cache write port.
- Sits between the cache's miss output and the read-response/data return path of the PageRank CSR pull compute unit.

---
 rtl/cu_vertex_cache_fill_engine.sv | 170 +++++++++++++++++
 tb/tb_cu_vertex_cache_fill_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_vertex_cache_fill_engine.sv
// Vertex cache fill engine: tracks outstanding misses by tag, captures the requested word
// from returning half-cachelines and emits one fill record per successful DONE response.
module cu_vertex_cache_fill_engine #(
  parameter int TAG_ENTRIES    = 32,
  parameter int WORDS_PER_HALF = 16,
  parameter int ID_BITS        = 32,
  parameter int DATA_BITS      = 32,
  parameter int TAG_BITS       = 8,
  parameter int RESP_BITS      = 2,
  // Bus layouts (MSB first): miss {valid, tag, address_offset}; response {valid, tag, code};
  // read data {valid, tag, data}; fill {valid, id, data}. Response code 0 is DONE.
  localparam int CMD_W  = 1 + TAG_BITS + ID_BITS,
  localparam int RSP_W  = 1 + TAG_BITS + RESP_BITS,
  localparam int HALF_W = WORDS_PER_HALF * DATA_BITS,
  localparam int RD_W   = 1 + TAG_BITS + HALF_W,
  localparam int FILL_W = 1 + ID_BITS + DATA_BITS,
  localparam int CNT_W  = $clog2(TAG_ENTRIES) + 1
) (
  input  logic              clock,
  input  logic              rst_in,
  input  logic              enabled_in,
  input  logic [CMD_W-1:0]  miss_command_in,
  input  logic [RSP_W-1:0]  read_response_in,
  input  logic [RD_W-1:0]   read_data_0_in,
  input  logic [RD_W-1:0]   read_data_1_in,
  output logic [FILL_W-1:0] fill_out,
  output logic [CNT_W-1:0]  pending_count_out,
  output logic [31:0]       error_count_out
);

  localparam int IDX_W  = $clog2(TAG_ENTRIES);
  localparam int WSEL_W = $clog2(WORDS_PER_HALF);
  localparam logic [RESP_BITS-1:0] RESP_DONE = '0;

  logic              en_q;
  logic [CMD_W-1:0]  miss_q;
  logic [RSP_W-1:0]  resp_q;
  logic [RD_W-1:0]   rd0_q, rd1_q;

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      en_q   <= 1'b0;
      miss_q <= '0;
      resp_q <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      en_q   <= enabled_in;
      miss_q <= miss_command_in;
      resp_q <= read_response_in;
      rd0_q  <= read_data_0_in;
      rd1_q  <= read_data_1_in;
    end
  end

  logic                 miss_v, resp_v, rd0_v, rd1_v;
  logic [IDX_W-1:0]     miss_idx, resp_idx, rd0_idx, rd1_idx;
  logic [ID_BITS-1:0]   miss_id;
  logic [RESP_BITS-1:0] resp_code;
  logic [HALF_W-1:0]    rd0_line, rd1_line;
  logic                 unused_tag_bits;

  assign miss_v    = miss_q[CMD_W-1];
  assign miss_idx  = miss_q[ID_BITS +: IDX_W];
  assign miss_id   = miss_q[ID_BITS-1:0];
  assign resp_v    = resp_q[RSP_W-1];
  assign resp_idx  = resp_q[RESP_BITS +: IDX_W];
  assign resp_code = resp_q[RESP_BITS-1:0];
  assign rd0_v     = rd0_q[RD_W-1];
  assign rd0_idx   = rd0_q[HALF_W +: IDX_W];
  assign rd0_line  = rd0_q[HALF_W-1:0];
  assign rd1_v     = rd1_q[RD_W-1];
  assign rd1_idx   = rd1_q[HALF_W +: IDX_W];
  assign rd1_line  = rd1_q[HALF_W-1:0];
  // Tags are folded modulo the table depth; the upper tag bits carry no meaning here.
  assign unused_tag_bits = ^{miss_q[ID_BITS+IDX_W +: TAG_BITS-IDX_W],
                             resp_q[RESP_BITS+IDX_W +: TAG_BITS-IDX_W],
                             rd0_q[HALF_W+IDX_W +: TAG_BITS-IDX_W],
                             rd1_q[HALF_W+IDX_W +: TAG_BITS-IDX_W]};

  logic [TAG_ENTRIES-1:0] pending_q, pending_d, captured_q, captured_d;
  logic [ID_BITS-1:0]     id_q   [TAG_ENTRIES];
  logic [DATA_BITS-1:0]   word_q [TAG_ENTRIES];
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [31:0]            error_count_q, error_count_d;

  function automatic logic [DATA_BITS-1:0] sel_word(input logic [HALF_W-1:0] line,
                                                    input logic [ID_BITS-1:0] id);
    logic [DATA_BITS-1:0] w;
    w = '0;
    for (int j = 0; j < WORDS_PER_HALF; j++) begin
      if (id[WSEL_W-1:0] == WSEL_W'(j)) w = line[j*DATA_BITS +: DATA_BITS];
    end
    return w;
  endfunction

  logic                 cap0, cap1, fwd0, fwd1, fwd_cap;
  logic                 resp_clear, fill_v, resp_err, miss_install, miss_coll;
  logic [DATA_BITS-1:0] w0, w1, fwd_word;
  logic [32:0]          err_sum;

  always_comb begin
    w0 = sel_word(rd0_line, id_q[rd0_idx]);
    w1 = sel_word(rd1_line, id_q[rd1_idx]);
    // A beat only lands if its half matches the half the pending vertex lives in.
    cap0 = rd0_v && pending_q[rd0_idx] && !id_q[rd0_idx][WSEL_W];
    cap1 = rd1_v && pending_q[rd1_idx] &&  id_q[rd1_idx][WSEL_W];
    fwd0 = cap0 && (rd0_idx == resp_idx);
    fwd1 = cap1 && (rd1_idx == resp_idx);
    fwd_cap  = captured_q[resp_idx] | fwd0 | fwd1;
    fwd_word = fwd1 ? w1 : (fwd0 ? w0 : word_q[resp_idx]);

    // While disabled, responses are swallowed without touching the entry or the error count.
    resp_clear = resp_v && en_q && pending_q[resp_idx];
    fill_v     = resp_clear && (resp_code == RESP_DONE) && fwd_cap;
    resp_err   = resp_v && en_q && !fill_v;
    miss_install = miss_v && en_q;
    miss_coll    = miss_install && pending_q[miss_idx] && !(resp_clear && (resp_idx == miss_idx));

    pending_d  = pending_q;
    captured_d = captured_q;
    if (cap0) captured_d[rd0_idx] = 1'b1;
    if (cap1) captured_d[rd1_idx] = 1'b1;
    if (resp_clear) begin
      pending_d[resp_idx]  = 1'b0;
      captured_d[resp_idx] = 1'b0;
    end
    if (miss_install) begin
      pending_d[miss_idx]  = 1'b1;
      captured_d[miss_idx] = 1'b0;
    end

    fill_d = fill_v ? {1'b1, id_q[resp_idx], fwd_word} : '0;

    count_d = '0;
    for (int i = 0; i < TAG_ENTRIES; i++) count_d = count_d + CNT_W'(pending_d[i]);

    err_sum       = {1'b0, error_count_q} + 33'(resp_err) + 33'(miss_coll);
    error_count_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      pending_q     <= '0;
      captured_q    <= '0;
      fill_q        <= '0;
      count_q       <= '0;
      error_count_q <= '0;
    end else begin
      pending_q     <= pending_d;
      captured_q    <= captured_d;
      fill_q        <= fill_d;
      count_q       <= count_d;
      error_count_q <= error_count_d;
    end
  end

  // Entry payloads are qualified by pending/captured, so they need no reset.
  always_ff @(posedge clock) begin
    if (cap0) word_q[rd0_idx] <= w0;
    if (cap1) word_q[rd1_idx] <= w1;
    if (miss_install) id_q[miss_idx] <= miss_id;
  end

  assign fill_out          = fill_q;
  assign pending_count_out = count_q;
  assign error_count_out   = error_count_q;

endmodule

// File: tb/tb_cu_vertex_cache_fill_engine.sv
// Self-checking bench for cu_vertex_cache_fill_engine: directed table, multi-cycle
// sequences and randomized traffic compared against a rule-level table model.
module tb_cu_vertex_cache_fill_engine;

  localparam int TE = 32, WPH = 16, IDB = 32, DB = 32, TGB = 8, RB = 2;
  localparam int CMD_W = 1 + TGB + IDB, RSP_W = 1 + TGB + RB, HALF_W = WPH * DB;
  localparam int RD_W = 1 + TGB + HALF_W, FILL_W = 1 + IDB + DB;
  localparam logic [1:0] R_DONE = 2'd0, R_FAILED = 2'd1, R_NRES = 2'd2, R_AERROR = 2'd3;

  logic              clock = 1'b0;
  logic              rst_in = 1'b1;
  logic              enabled_in = 1'b0;
  logic [CMD_W-1:0]  miss_command_in = '0;
  logic [RSP_W-1:0]  read_response_in = '0;
  logic [RD_W-1:0]   read_data_0_in = '0;
  logic [RD_W-1:0]   read_data_1_in = '0;
  logic [FILL_W-1:0] fill_out;
  logic [5:0]        pending_count_out;
  logic [31:0]       error_count_out;

  cu_vertex_cache_fill_engine #(
    .TAG_ENTRIES(TE), .WORDS_PER_HALF(WPH), .ID_BITS(IDB), .DATA_BITS(DB),
    .TAG_BITS(TGB), .RESP_BITS(RB)
  ) dut (
    .clock(clock), .rst_in(rst_in), .enabled_in(enabled_in),
    .miss_command_in(miss_command_in), .read_response_in(read_response_in),
    .read_data_0_in(read_data_0_in), .read_data_1_in(read_data_1_in),
    .fill_out(fill_out), .pending_count_out(pending_count_out),
    .error_count_out(error_count_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit en;
    bit mv;  int unsigned mt;  logic [31:0] mid;
    bit d0v; int unsigned d0t; int unsigned d0w; logic [31:0] d0x;
    bit d1v; int unsigned d1t; int unsigned d1w; logic [31:0] d1x;
    bit rv;  int unsigned rt;  logic [1:0] rc;
    bit chk; bit ev; logic [31:0] eid; logic [31:0] edat;
    int unsigned epend; logic [31:0] eerr;
  } vec_t;

  typedef struct {
    vec_t v;
    logic [HALF_W-1:0] l0, l1;
  } stage_t;

  int checks = 0, failures = 0, fills_seen = 0;

  // Reference model: one record per tag slot, updated by the rules in event order.
  bit          m_pend [TE];
  bit          m_cap  [TE];
  logic [31:0] m_id   [TE];
  logic [31:0] m_word [TE];
  logic [31:0] m_err;
  logic [FILL_W-1:0] m_fill;
  int unsigned m_count;

  stage_t p, pp;
  bit p_ok = 0, pp_ok = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TE; i++) begin
      m_pend[i] = 0; m_cap[i] = 0; m_id[i] = '0; m_word[i] = '0;
    end
    m_err = '0; m_fill = '0; m_count = 0;
  endtask

  task automatic bump_err();
    if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
  endtask

  task automatic model_apply(input stage_t s);
    int unsigned t;
    m_fill = '0;
    if (s.v.d0v) begin
      t = s.v.d0t % TE;
      if (m_pend[t] && ((m_id[t] / WPH) % 2) == 0) begin
        m_word[t] = s.l0[DB*(m_id[t] % WPH) +: DB];
        m_cap[t]  = 1;
      end
    end
    if (s.v.d1v) begin
      t = s.v.d1t % TE;
      if (m_pend[t] && ((m_id[t] / WPH) % 2) == 1) begin
        m_word[t] = s.l1[DB*(m_id[t] % WPH) +: DB];
        m_cap[t]  = 1;
      end
    end
    if (s.v.rv && s.v.en) begin
      t = s.v.rt % TE;
      if (m_pend[t] && s.v.rc == R_DONE && m_cap[t]) m_fill = {1'b1, m_id[t], m_word[t]};
      else bump_err();
      m_pend[t] = 0;
      m_cap[t]  = 0;
    end
    if (s.v.mv && s.v.en) begin
      t = s.v.mt % TE;
      if (m_pend[t]) bump_err();
      m_pend[t] = 1;
      m_cap[t]  = 0;
      m_id[t]   = s.v.mid;
    end
    m_count = 0;
    for (int i = 0; i < TE; i++) m_count += m_pend[i];
  endtask

  task automatic compare(input stage_t s);
    check_eq("fill_model", fill_out, m_fill);
    check_eq("pending_model", pending_count_out, m_count);
    check_eq("errors_model", error_count_out, m_err);
    if (s.v.chk) begin
      check_eq("fill_table", fill_out, s.v.ev ? {1'b1, s.v.eid, s.v.edat} : 65'b0);
      check_eq("pending_table", pending_count_out, s.v.epend);
      check_eq("errors_table", error_count_out, s.v.eerr);
    end
    if (fill_out[FILL_W-1]) fills_seen++;
  endtask

  task automatic drive(input stage_t s);
    enabled_in       = s.v.en;
    miss_command_in  = {s.v.mv, 8'(s.v.mt), s.v.mid};
    read_data_0_in   = {s.v.d0v, 8'(s.v.d0t), s.l0};
    read_data_1_in   = {s.v.d1v, 8'(s.v.d1t), s.l1};
    read_response_in = {s.v.rv, 8'(s.v.rt), s.v.rc};
  endtask

  // Outputs seen at a falling edge reflect the inputs driven two falling edges earlier.
  task automatic step(input stage_t s);
    @(negedge clock);
    if (pp_ok) begin
      model_apply(pp);
      compare(pp);
    end
    pp = p; pp_ok = p_ok;
    p = s;  p_ok = 1;
    drive(s);
  endtask

  function automatic logic [HALF_W-1:0] mkline(input int unsigned w, input logic [31:0] x,
                                               input int unsigned salt);
    logic [HALF_W-1:0] l;
    for (int j = 0; j < WPH; j++)
      l[32*j +: 32] = (j == int'(w)) ? x : (32'hBAD0_0000 | 32'(salt << 8) | 32'(j));
    return l;
  endfunction

  function automatic vec_t mk(input bit en, input bit mv, input int unsigned mt, input logic [31:0] mid,
                              input bit d0v, input int unsigned d0t, input int unsigned d0w, input logic [31:0] d0x,
                              input bit d1v, input int unsigned d1t, input int unsigned d1w, input logic [31:0] d1x,
                              input bit rv, input int unsigned rt, input logic [1:0] rc,
                              input bit ev, input logic [31:0] eid, input logic [31:0] edat,
                              input int unsigned epend, input logic [31:0] eerr);
    vec_t v;
    v.en = en; v.mv = mv; v.mt = mt; v.mid = mid;
    v.d0v = d0v; v.d0t = d0t; v.d0w = d0w; v.d0x = d0x;
    v.d1v = d1v; v.d1t = d1t; v.d1w = d1w; v.d1x = d1x;
    v.rv = rv; v.rt = rt; v.rc = rc;
    v.chk = 0; v.ev = ev; v.eid = eid; v.edat = edat; v.epend = epend; v.eerr = eerr;
    return v;
  endfunction

  function automatic stage_t mkstage(input vec_t v);
    stage_t s;
    s.v  = v;
    s.l0 = mkline(v.d0w, v.d0x, v.d0t);
    s.l1 = mkline(v.d1w, v.d1x, v.d1t + 7);
    return s;
  endfunction

  function automatic stage_t idle();
    return mkstage(mk(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,R_DONE, 0,0,0,0,0));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl [28];

  initial begin
    int unsigned f0;
    stage_t s;
    //              en mv mt  mid     d0v t w x               d1v t w x             rv t  rc        ev id     data          pend err
    tbl[0]  = mk(1, 1, 3, 'h25,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 0);
    tbl[1]  = mk(1, 0, 0, 0,      1,3,5,'hDEADBEEF,       1,3,5,'h12345678,     0,0,R_DONE,   0,0,0,            1, 0);
    tbl[2]  = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,3,R_DONE,   1,'h25,'hDEADBEEF, 0, 0);
    tbl[3]  = mk(1, 1, 3, 'h35,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 0);
    tbl[4]  = mk(1, 0, 0, 0,      1,3,5,'h0BADBAD0,       1,3,5,'hCAFEF00D,     1,3,R_DONE,   1,'h35,'hCAFEF00D, 0, 0);
    tbl[5]  = mk(1, 1, 7, 'h03,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 0);
    tbl[6]  = mk(1, 0, 0, 0,      1,7,3,'h11,             0,0,0,0,              1,7,R_DONE,   1,'h03,'h11,      0, 0);
    tbl[7]  = mk(1, 1, 2, 'h40,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 0);
    tbl[8]  = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,2,R_AERROR, 0,0,0,            0, 1);
    tbl[9]  = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,9,R_DONE,   0,0,0,            0, 2);
    tbl[10] = mk(1, 1, 4, 'h10,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 2);
    tbl[11] = mk(1, 1, 4, 'h11,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 3);
    tbl[12] = mk(1, 0, 0, 0,      1,4,1,'h99,             1,4,1,'h44,           0,0,R_DONE,   0,0,0,            1, 3);
    tbl[13] = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,4,R_DONE,   1,'h11,'h44,      0, 3);
    tbl[14] = mk(1, 1, 5, 'h06,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 3);
    tbl[15] = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,5,R_DONE,   0,0,0,            0, 4);
    tbl[16] = mk(0, 1, 6, 'h08,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            0, 4);
    tbl[17] = mk(0, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,6,R_DONE,   0,0,0,            0, 4);
    tbl[18] = mk(1, 1, 6, 'h08,   0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 4);
    tbl[19] = mk(0, 0, 0, 0,      1,6,8,'h66,             0,0,0,0,              1,6,R_DONE,   0,0,0,            1, 4);
    tbl[20] = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,6,R_DONE,   1,'h08,'h66,      0, 4);
    tbl[21] = mk(1, 1, 1, 'h01,   0,0,0,0,                0,0,0,0,              1,1,R_DONE,   0,0,0,            1, 5);
    tbl[22] = mk(1, 1, 1, 'h02,   0,0,0,0,                0,0,0,0,              1,1,R_DONE,   0,0,0,            1, 6);
    tbl[23] = mk(1, 0, 0, 0,      1,1,2,'h22,             0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 6);
    tbl[24] = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              1,1,R_DONE,   1,'h02,'h22,      0, 6);
    tbl[25] = mk(1, 1, 35, 'h07,  0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            1, 6);
    tbl[26] = mk(1, 0, 0, 0,      1,35,7,'h77,            0,0,0,0,              1,3,R_DONE,   1,'h07,'h77,      0, 6);
    tbl[27] = mk(1, 0, 0, 0,      0,0,0,0,                0,0,0,0,              0,0,R_DONE,   0,0,0,            0, 6);

    model_reset();
    drive(idle());
    repeat (3) @(negedge clock);
    check_eq("reset_fill", fill_out, 0);
    check_eq("reset_pending", pending_count_out, 0);
    check_eq("reset_errors", error_count_out, 0);
    rst_in = 1'b0;

    // Directed table.
    for (int i = 0; i < 28; i++) begin
      tbl[i].chk = 1;
      step(mkstage(tbl[i]));
    end
    repeat (2) step(idle());

    // Fill every slot, deliver each word, then answer in reverse order.
    for (int i = 0; i < TE; i++)
      step(mkstage(mk(1, 1, i, 'h100 + i, 0,0,0,0, 0,0,0,0, 0,0,R_DONE, 0,0,0,0,0)));
    repeat (2) step(idle());
    check_eq("pending_full", pending_count_out, 32);
    for (int i = 0; i < TE; i++) begin
      if (((i / WPH) % 2) == 0)
        step(mkstage(mk(1, 0,0,0, 1,i,i % WPH,'hF000 + i, 0,0,0,0, 0,0,R_DONE, 0,0,0,0,0)));
      else
        step(mkstage(mk(1, 0,0,0, 0,0,0,0, 1,i,i % WPH,'hF000 + i, 0,0,R_DONE, 0,0,0,0,0)));
    end
    f0 = fills_seen;
    for (int i = TE - 1; i >= 0; i--)
      step(mkstage(mk(1, 0,0,0, 0,0,0,0, 0,0,0,0, 1,i,R_DONE, 0,0,0,0,0)));
    repeat (2) step(idle());
    check_eq("reverse_fill_count", fills_seen - f0, 32);
    check_eq("pending_drained", pending_count_out, 0);

    // Reset in the middle of traffic with five misses pending.
    for (int i = 10; i < 15; i++)
      step(mkstage(mk(1, 1, i, 'h20 + i, 0,0,0,0, 0,0,0,0, 0,0,R_DONE, 0,0,0,0,0)));
    repeat (2) step(idle());
    check_eq("pending_before_reset", pending_count_out, 5);
    @(negedge clock);
    #2 rst_in = 1'b1;
    #1;
    check_eq("async_reset_fill", fill_out, 0);
    check_eq("async_reset_pending", pending_count_out, 0);
    check_eq("async_reset_errors", error_count_out, 0);
    drive(idle());
    model_reset();
    p_ok = 0; pp_ok = 0;
    @(negedge clock);
    rst_in = 1'b0;
    f0 = fills_seen;
    for (int i = 10; i < 15; i++)
      step(mkstage(mk(1, 0,0,0, 0,0,0,0, 0,0,0,0, 1,i,R_DONE, 0,0,0,0,0)));
    repeat (2) step(idle());
    check_eq("no_fill_after_reset", fills_seen - f0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.v.en  = ($urandom_range(0, 9) != 0);
      s.v.mv  = $urandom_range(0, 1);
      s.v.mt  = $urandom_range(0, 63);
      s.v.mid = $urandom_range(0, 255);
      s.v.d0v = $urandom_range(0, 1);
      s.v.d0t = $urandom_range(0, 63);
      s.v.d1v = $urandom_range(0, 1);
      s.v.d1t = $urandom_range(0, 63);
      s.v.rv  = ($urandom_range(0, 2) != 0);
      s.v.rt  = $urandom_range(0, 63);
      s.v.rc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : R_DONE;
      for (int j = 0; j < WPH; j++) begin
        s.l0[32*j +: 32] = $urandom;
        s.l1[32*j +: 32] = $urandom;
      end
      step(s);
    end
    repeat (2) step(idle());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
